// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM fade sequencer.
//   seq_state_e : sequencer FSM states
//   DEF_VAL_W   : default duty width (matches the pwm value input)
//   DEF_DIV_W   : default step prescaler width
package pwm_seq_pkg;

  localparam int unsigned DEF_VAL_W = 8;
  localparam int unsigned DEF_DIV_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    HOLD_HI,
    DOWN,
    HOLD_LO
  } seq_state_e;

endpackage

// File: rtl/pwm_fade_seq_if.sv
// Control/config and pwm write-port bundle for pwm_fade_seq.
//   master : drives start/stop/config, observes the pwm write strobe and status
//   slave  : the sequencer side
// Signals:
//   start, stop, one_shot        control pulses / mode
//   floor, peak                  duty bounds (VAL_W)
//   step_div                     step period minus 1 (DIV_W)
//   hold_steps                   extra steps dwelt at each extreme
//   pwm_en, pwm_value            one-cycle write strobe and duty
//   busy, done                   sequence status
interface pwm_fade_seq_if #(
  parameter int unsigned VAL_W = pwm_seq_pkg::DEF_VAL_W,
  parameter int unsigned DIV_W = pwm_seq_pkg::DEF_DIV_W
);

  logic             start;
  logic             stop;
  logic             one_shot;
  logic [VAL_W-1:0] floor;
  logic [VAL_W-1:0] peak;
  logic [DIV_W-1:0] step_div;
  logic [7:0]       hold_steps;
  logic             pwm_en;
  logic [VAL_W-1:0] pwm_value;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, one_shot, floor, peak, step_div, hold_steps,
    input  pwm_en, pwm_value, busy, done
  );

  modport slave (
    input  start, stop, one_shot, floor, peak, step_div, hold_steps,
    output pwm_en, pwm_value, busy, done
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// Step prescaler: counts 0..step_div and asserts tick while the count
// equals step_div, then wraps. A synchronous clear restarts the count so
// the first tick lands step_div+1 cycles after the clear edge.
//   CLK, RST_N : clock, async active-low reset
//   clr        : synchronous clear
//   step_div   : terminal count
//   tick       : step strobe (combinational from the count register)
module pwm_tick_gen #(
  parameter int unsigned DIV_W = pwm_seq_pkg::DEF_DIV_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == step_div);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_fade_seq.sv
// Triangle "breathing" sequencer for the pwm write port. Ramps duty from
// floor to peak and back in steps of step_div+1 cycles, dwelling
// hold_steps+1 steps at each extreme; one-shot or continuous.
//   CLK, RST_N : clock, async active-low reset
//   bus        : pwm_fade_seq_if.slave (start/stop/config in, pwm write
//                strobe and busy/done out); all outputs are registered
module pwm_fade_seq #(
  parameter int unsigned VAL_W = pwm_seq_pkg::DEF_VAL_W,
  parameter int unsigned DIV_W = pwm_seq_pkg::DEF_DIV_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  pwm_fade_seq_if.slave  bus
);

  import pwm_seq_pkg::*;

  seq_state_e       state_q, state_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       hold_q, hold_d;

  logic [VAL_W-1:0] floor_q, floor_d;
  logic [VAL_W-1:0] peak_q, peak_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       hs_q, hs_d;
  logic             os_q, os_d;

  logic             clr;
  logic             tick;
  logic [VAL_W-1:0] val_inc;
  logic [VAL_W-1:0] val_dec;
  logic [VAL_W-1:0] floor_inc;

  assign val_inc   = value_q + 1'b1;
  assign val_dec   = value_q - 1'b1;
  assign floor_inc = floor_q + 1'b1;

  pwm_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (clr),
    .step_div (div_q),
    .tick     (tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      value_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
      floor_q <= '0;
      peak_q  <= '0;
      div_q   <= '0;
      hs_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      floor_q <= floor_d;
      peak_q  <= peak_d;
      div_q   <= div_d;
      hs_q    <= hs_d;
      os_q    <= os_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    floor_d = floor_q;
    peak_d  = peak_q;
    div_d   = div_q;
    hs_d    = hs_q;
    os_d    = os_q;
    clr     = 1'b0;

    if (bus.stop) begin
      // stop overrides everything, including a simultaneous start
      en_d    = 1'b1;
      value_d = '0;
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            floor_d = bus.floor;
            peak_d  = bus.peak;
            div_d   = bus.step_div;
            hs_d    = bus.hold_steps;
            os_d    = bus.one_shot;
            clr     = 1'b1;
            en_d    = 1'b1;
            value_d = bus.floor;
            if (bus.floor >= bus.peak) begin
              // nothing to ramp: finish on the start edge
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              busy_d  = 1'b1;
              state_d = UP;
            end
          end
        end

        UP: begin
          if (tick) begin
            en_d    = 1'b1;
            value_d = val_inc;
            if (val_inc == peak_q) begin
              state_d = HOLD_HI;
              hold_d  = '0;
            end
          end
        end

        HOLD_HI: begin
          if (tick) begin
            if (hold_q == hs_q) begin
              en_d    = 1'b1;
              value_d = val_dec;
              if (val_dec == floor_q) begin
                state_d = HOLD_LO;
                hold_d  = '0;
              end else begin
                state_d = DOWN;
              end
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end

        DOWN: begin
          if (tick) begin
            en_d    = 1'b1;
            value_d = val_dec;
            if (val_dec == floor_q) begin
              state_d = HOLD_LO;
              hold_d  = '0;
            end
          end
        end

        HOLD_LO: begin
          if (tick) begin
            if (hold_q == hs_q) begin
              if (os_q) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                en_d    = 1'b1;
                value_d = floor_inc;
                if (floor_inc == peak_q) begin
                  state_d = HOLD_HI;
                  hold_d  = '0;
                end else begin
                  state_d = UP;
                end
              end
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.pwm_en    = en_q;
  assign bus.pwm_value = value_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pwm_fade_seq.sv
module tb_pwm_fade_seq;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  pwm_fade_seq_if #(.VAL_W(8), .DIV_W(18)) bus ();

  pwm_fade_seq #(
    .VAL_W (8),
    .DIV_W (18)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct packed {
    logic        is_done;
    int unsigned cyc;
    logic [7:0]  val;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push_wr(input int unsigned c, input logic [7:0] v);
    ev_t e;
    e.is_done = 1'b0;
    e.cyc     = c;
    e.val     = v;
    sb.push_back(e);
  endtask

  task automatic push_done(input int unsigned c);
    ev_t e;
    e.is_done = 1'b1;
    e.cyc     = c;
    e.val     = 8'd0;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every strobe or done pulse must match the head entry.
  task automatic check_event(input logic is_done, input logic [7:0] v);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got value %0d at cycle %0d, required no event",
               is_done ? "done" : "write", v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.is_done != is_done || e.cyc != cyc || (!is_done && e.val != v)) begin
        miscompares++;
        $display("FAIL event: got %s val=%0d cyc=%0d, required %s val=%0d cyc=%0d",
                 is_done ? "done" : "write", v, cyc,
                 e.is_done ? "done" : "write", e.val, e.cyc);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (bus.pwm_en) check_event(1'b0, bus.pwm_value);
      if (bus.done)   check_event(1'b1, 8'd0);
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic begin_start(input logic [7:0] f, input logic [7:0] p,
                             input logic [17:0] d, input logic [7:0] h,
                             input logic os, input logic stp,
                             output int unsigned t);
    @(negedge CLK);
    bus.floor      = f;
    bus.peak       = p;
    bus.step_div   = d;
    bus.hold_steps = h;
    bus.one_shot   = os;
    bus.start      = 1'b1;
    bus.stop       = stp;
    t = cyc + 1;
  endtask

  task automatic end_pulse();
    @(negedge CLK);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic stop_at(input int unsigned edge_c);
    wait_until(edge_c - 1);
    bus.stop = 1'b1;
    push_wr(edge_c, 8'd0);
    end_pulse();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    check(name, sb.size(), 0);
  endtask

  logic [7:0] ramp[9];

  initial begin
    int unsigned t;
    ramp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.one_shot = 1'b0;
    bus.floor = '0;
    bus.peak = '0;
    bus.step_div = '0;
    bus.hold_steps = '0;

    // reset values
    repeat (2) @(negedge CLK);
    check("reset_en", bus.pwm_en, 0);
    check("reset_value", bus.pwm_value, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // basic one-shot ramp, with a config change + start mid-sequence
    begin_start(8'd0, 8'd4, 18'd3, 8'd0, 1'b1, 1'b0, t);
    for (int i = 0; i < 9; i++) push_wr(t + 4 * i, ramp[i]);
    push_done(t + 36);
    end_pulse();
    check("basic_busy_after_start", bus.busy, 1);
    wait_until(t + 6);
    bus.floor = 8'd9;
    bus.peak = 8'd2;
    bus.step_div = 18'd0;
    bus.hold_steps = 8'd5;
    bus.one_shot = 1'b0;
    bus.start = 1'b1;
    end_pulse();
    wait_until(t + 35);
    check("basic_busy_before_done", bus.busy, 1);
    wait_until(t + 36);
    check("basic_busy_at_done", bus.busy, 0);
    drain("basic_drain");

    // degenerate: floor == peak
    begin_start(8'd7, 8'd7, 18'd5, 8'd0, 1'b0, 1'b0, t);
    push_wr(t, 8'd7);
    push_done(t);
    end_pulse();
    check("degen_busy", bus.busy, 0);
    drain("degen_drain");

    // peak - floor == 1: alternating writes every step
    begin_start(8'd5, 8'd6, 18'd1, 8'd0, 1'b1, 1'b0, t);
    push_wr(t, 8'd5);
    push_wr(t + 2, 8'd6);
    push_wr(t + 4, 8'd5);
    push_done(t + 6);
    end_pulse();
    wait_until(t + 5);
    check("alt_busy_mid", bus.busy, 1);
    wait_until(t + 6);
    check("alt_busy_end", bus.busy, 0);
    drain("alt_drain");

    // start and stop together while idle: stop wins
    begin_start(8'd1, 8'd9, 18'd0, 8'd0, 1'b1, 1'b1, t);
    push_wr(t, 8'd0);
    end_pulse();
    check("collide_busy", bus.busy, 0);
    repeat (5) @(negedge CLK);
    drain("collide_drain");

    // stop during HOLD_HI
    begin_start(8'd0, 8'd3, 18'd2, 8'd3, 1'b1, 1'b0, t);
    push_wr(t, 8'd0);
    push_wr(t + 3, 8'd1);
    push_wr(t + 6, 8'd2);
    push_wr(t + 9, 8'd3);
    end_pulse();
    stop_at(t + 15);
    check("stop_hold_busy", bus.busy, 0);
    repeat (20) @(negedge CLK);
    drain("stop_hold_drain");

    // continuous: 240-cycle period between floor+1 writes
    begin_start(8'd10, 8'd20, 18'd9, 8'd2, 1'b0, 1'b0, t);
    push_wr(t, 8'd10);
    for (int p = 0; p < 2; p++) begin
      for (int v = 11; v <= 20; v++) push_wr(t + 10 + 240 * p + 10 * (v - 11), 8'(v));
      for (int v = 19; v >= 10; v--) push_wr(t + 130 + 240 * p + 10 * (19 - v), 8'(v));
    end
    push_wr(t + 490, 8'd11);
    end_pulse();
    wait_until(t + 300);
    check("cont_busy_mid", bus.busy, 1);
    stop_at(t + 495);
    check("cont_busy_after_stop", bus.busy, 0);
    check("cont_value_after_stop", bus.pwm_value, 0);
    drain("cont_drain");

    // async reset during DOWN
    begin_start(8'd0, 8'd4, 18'd3, 8'd0, 1'b1, 1'b0, t);
    for (int i = 0; i < 7; i++) push_wr(t + 4 * i, ramp[i]);
    end_pulse();
    wait_until(t + 26);
    check("pre_reset_value", bus.pwm_value, 2);
    #2 RST_N = 1'b0;
    #1;
    check("areset_en", bus.pwm_en, 0);
    check("areset_value", bus.pwm_value, 0);
    check("areset_busy", bus.busy, 0);
    check("areset_done", bus.done, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    wait_until(cyc + 10);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_value", bus.pwm_value, 0);
    drain("reset_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
